// File: rtl/alu_mult_seq.sv
// alu_mult_seq: multi-cycle unsigned WIDTH x WIDTH -> 2*WIDTH shift-add multiplier.
// It reuses the datapath's external ALU as its adder, one add per cycle. Each
// RUN cycle it presents {ProdHi, Mcand-or-0} to the ALU as an ADD, then shifts
// the carry, the sum and the remaining multiplier bits right by one place.
// All outputs come straight from flops. The next-cycle ALU operands are
// therefore computed from the next-state values of the product registers.
module alu_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [WIDTH-1:0]     MultA,
    input  logic [WIDTH-1:0]     MultB,
    output logic                 Busy,
    output logic                 Done,
    output logic [2*WIDTH-1:0]   Product,
    output logic [1:0]           ALUOp,
    output logic [WIDTH-1:0]     ALUSrcA,
    output logic [WIDTH-1:0]     ALUSrcB,
    input  logic [WIDTH-1:0]     ALUResult
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;

    // Carry out of an unsigned add, recovered from the wrapped sum alone.
    // When the addend is zero the sum equals the augend, so no carry is seen.
    function automatic logic add_carry(input logic [WIDTH-1:0] sum,
                                       input logic [WIDTH-1:0] augend);
        add_carry = (sum < augend);
    endfunction

    // Architectural state
    logic [1:0]        state_r;
    logic [WIDTH-1:0]  mcand_r;
    logic [WIDTH-1:0]  prod_hi_r;
    logic [WIDTH-1:0]  prod_lo_r;
    logic [CNT_W-1:0]  count_r;

    // Registered outputs
    logic              busy_r;
    logic              done_r;
    logic [1:0]        alu_op_r;
    logic [WIDTH-1:0]  alu_src_a_r;
    logic [WIDTH-1:0]  alu_src_b_r;

    // Next-state values
    logic [1:0]        state_nxt_s;
    logic [WIDTH-1:0]  mcand_nxt_s;
    logic [WIDTH-1:0]  prod_hi_nxt_s;
    logic [WIDTH-1:0]  prod_lo_nxt_s;
    logic [CNT_W-1:0]  count_nxt_s;
    logic              carry_s;

    // Next-output values
    logic              busy_nxt_s;
    logic              done_nxt_s;
    logic [1:0]        alu_op_nxt_s;
    logic [WIDTH-1:0]  alu_src_a_nxt_s;
    logic [WIDTH-1:0]  alu_src_b_nxt_s;

    // Sequencing and datapath next state: load on Start, one shift-add per RUN cycle
    always_comb begin
        state_nxt_s   = state_r;
        mcand_nxt_s   = mcand_r;
        prod_hi_nxt_s = prod_hi_r;
        prod_lo_nxt_s = prod_lo_r;
        count_nxt_s   = count_r;
        carry_s       = add_carry(ALUResult, prod_hi_r);
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    state_nxt_s   = ST_RUN;
                    mcand_nxt_s   = MultA;
                    prod_hi_nxt_s = {WIDTH{1'b0}};
                    prod_lo_nxt_s = MultB;
                    count_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_RUN: begin
                // {hi, lo} <= {carry, sum, lo >> 1}
                prod_hi_nxt_s = {carry_s, ALUResult[WIDTH-1:1]};
                prod_lo_nxt_s = {ALUResult[0], prod_lo_r[WIDTH-1:1]};
                count_nxt_s   = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                if (count_r == LAST_CNT) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state so the outputs can be flopped
    always_comb begin
        busy_nxt_s      = 1'b0;
        done_nxt_s      = 1'b0;
        alu_op_nxt_s    = OP_AND;
        alu_src_a_nxt_s = {WIDTH{1'b0}};
        alu_src_b_nxt_s = {WIDTH{1'b0}};
        case (state_nxt_s)
            ST_RUN: begin
                busy_nxt_s      = 1'b1;
                alu_op_nxt_s    = OP_ADD;
                alu_src_a_nxt_s = prod_hi_nxt_s;
                if (prod_lo_nxt_s[0]) begin
                    alu_src_b_nxt_s = mcand_nxt_s;
                end else begin
                    alu_src_b_nxt_s = {WIDTH{1'b0}};
                end
            end
            ST_DONE: begin
                done_nxt_s = 1'b1;
            end
            ST_IDLE: begin
                busy_nxt_s = 1'b0;
            end
            default: begin
                busy_nxt_s = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers; synchronous reset discards any in-flight multiply
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_r     <= ST_IDLE;
            mcand_r     <= {WIDTH{1'b0}};
            prod_hi_r   <= {WIDTH{1'b0}};
            prod_lo_r   <= {WIDTH{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            alu_op_r    <= OP_AND;
            alu_src_a_r <= {WIDTH{1'b0}};
            alu_src_b_r <= {WIDTH{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            mcand_r     <= mcand_nxt_s;
            prod_hi_r   <= prod_hi_nxt_s;
            prod_lo_r   <= prod_lo_nxt_s;
            count_r     <= count_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
            alu_op_r    <= alu_op_nxt_s;
            alu_src_a_r <= alu_src_a_nxt_s;
            alu_src_b_r <= alu_src_b_nxt_s;
        end
    end

    assign Busy    = busy_r;
    assign Done    = done_r;
    assign Product = {prod_hi_r, prod_lo_r};
    assign ALUOp   = alu_op_r;
    assign ALUSrcA = alu_src_a_r;
    assign ALUSrcB = alu_src_b_r;

endmodule

// File: tb/tb_alu_mult_seq.sv
// Self-checking bench for alu_mult_seq: an ideal ALU closes the loop, and
// expected products and per-iteration ALU operands come from plain arithmetic.
module tb_alu_mult_seq;

    localparam int W = 8;

    logic           CLK;
    logic           Reset;
    logic           Start;
    logic [W-1:0]   MultA;
    logic [W-1:0]   MultB;
    logic           Busy;
    logic           Done;
    logic [2*W-1:0] Product;
    logic [1:0]     ALUOp;
    logic [W-1:0]   ALUSrcA;
    logic [W-1:0]   ALUSrcB;
    logic [W-1:0]   ALUResult;

    int checks = 0;
    int errors = 0;

    alu_mult_seq #(.WIDTH(W)) dut (
        .CLK(CLK), .Reset(Reset), .Start(Start), .MultA(MultA), .MultB(MultB),
        .Busy(Busy), .Done(Done), .Product(Product), .ALUOp(ALUOp),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUResult(ALUResult)
    );

    // Clock generator
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Ideal combinational ALU
    always_comb begin
        ALUResult = 8'h00;
        case (ALUOp)
            2'b00:   ALUResult = ALUSrcA & ALUSrcB;
            2'b01:   ALUResult = ALUSrcA + ALUSrcB;
            2'b10:   ALUResult = ALUSrcA ^ ALUSrcB;
            default: ALUResult = ALUSrcA - ALUSrcB;
        endcase
    end

    // One accepted multiply: Start at a negedge, then 10 observed cycles.
    // With jitter_start set, Start toggles randomly while the multiply runs.
    // With scramble set, the operand inputs are changed while it runs.
    task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                            input bit jitter_start, input bit scramble, input string tag);
        logic [2*W-1:0] exp_p;
        logic [2*W-1:0] part;
        int             dones;
        exp_p = 16'(a) * 16'(b);
        dones = 0;
        @(negedge CLK);
        Start = 1'b1; MultA = a; MultB = b;
        @(posedge CLK);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge CLK);
            if (cyc <= 8) begin
                // Iteration cyc-1: multiplier bits below it are already summed.
                part = 16'(a) * 16'(b & 8'((9'd1 << (cyc - 1)) - 9'd1));
                part = part >> (cyc - 1);
                checks++;
                if (Busy !== 1'b1 || Done !== 1'b0 || ALUOp !== 2'b01) begin
                    errors++;
                    $display("FAIL %s run%0d ctl: busy=%b done=%b op=%b want 1 0 01", tag, cyc, Busy, Done, ALUOp);
                end
                checks++;
                if (ALUSrcB !== (b[cyc-1] ? a : 8'h00) || ALUSrcA !== part[W-1:0]) begin
                    errors++;
                    $display("FAIL %s run%0d operands: a=%h b=%h want a=%h b=%h", tag, cyc, ALUSrcA, ALUSrcB,
                             part[W-1:0], (b[cyc-1] ? a : 8'h00));
                end
            end else if (cyc == 9) begin
                checks++;
                if (Done !== 1'b1 || Busy !== 1'b0 || Product !== exp_p) begin
                    errors++;
                    $display("FAIL %s done: done=%b busy=%b product=%h want 1 0 %h", tag, Done, Busy, Product, exp_p);
                end
                checks++;
                if (ALUOp !== 2'b00 || ALUSrcA !== 8'h00 || ALUSrcB !== 8'h00) begin
                    errors++;
                    $display("FAIL %s done alu: op=%b a=%h b=%h want 00 00 00", tag, ALUOp, ALUSrcA, ALUSrcB);
                end
            end else begin
                checks++;
                if (Done !== 1'b0 || Busy !== 1'b0 || Product !== exp_p) begin
                    errors++;
                    $display("FAIL %s idle hold: done=%b busy=%b product=%h want 0 0 %h", tag, Done, Busy, Product, exp_p);
                end
            end
            if (Done === 1'b1) dones++;
            if (jitter_start && cyc <= 7) Start = 1'($urandom_range(0, 1));
            else Start = 1'b0;
            if (scramble) begin
                MultA = 8'($urandom);
                MultB = 8'($urandom);
            end
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL %s done pulses: got %0d want 1", tag, dones);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; Start = 1'b0; MultA = 8'h00; MultB = 8'h00;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || Product !== 16'h0000 ||
            ALUOp !== 2'b00 || ALUSrcA !== 8'h00 || ALUSrcB !== 8'h00) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b product=%h op=%b a=%h b=%h want all 0",
                     Busy, Done, Product, ALUOp, ALUSrcA, ALUSrcB);
        end
        Reset = 1'b0;
    endtask

    task automatic test_directed();
        run_mult(8'd13, 8'd11, 1'b0, 1'b0, "13x11");
        run_mult(8'd255, 8'd255, 1'b0, 1'b0, "255x255");
        run_mult(8'd0, 8'd200, 1'b0, 1'b0, "0x200");
        run_mult(8'd77, 8'd1, 1'b0, 1'b0, "77x1");
    endtask

    task automatic test_operand_change();
        run_mult(8'd181, 8'd93, 1'b0, 1'b1, "scramble");
    endtask

    task automatic test_extra_start();
        run_mult(8'd57, 8'd201, 1'b1, 1'b0, "jitter");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            run_mult(8'($urandom), 8'($urandom), i[0], i[1], "random");
        end
    endtask

    task automatic test_back_to_back();
        @(negedge CLK);
        Start = 1'b1; MultA = 8'd3; MultB = 8'd5;
        @(posedge CLK);
        @(negedge CLK);
        MultA = 8'd16; MultB = 8'd16;
        repeat (8) @(negedge CLK);
        checks++;
        if (Done !== 1'b1 || Product !== 16'h000F) begin
            errors++;
            $display("FAIL b2b first: done=%b product=%h want 1 000f", Done, Product);
        end
        @(negedge CLK);
        checks++;
        if (Done !== 1'b0 || Busy !== 1'b1 || ALUOp !== 2'b01) begin
            errors++;
            $display("FAIL b2b reload: done=%b busy=%b op=%b want 0 1 01", Done, Busy, ALUOp);
        end
        Start = 1'b0;
        repeat (8) @(negedge CLK);
        checks++;
        if (Done !== 1'b1 || Product !== 16'h0100) begin
            errors++;
            $display("FAIL b2b second: done=%b product=%h want 1 0100", Done, Product);
        end
        @(negedge CLK);
        checks++;
        if (Done !== 1'b0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b end: done=%b busy=%b want 0 0", Done, Busy);
        end
    endtask

    task automatic test_mid_reset();
        @(negedge CLK);
        Start = 1'b1; MultA = 8'd200; MultB = 8'd100;
        @(posedge CLK);
        @(negedge CLK);
        Start = 1'b0;
        repeat (3) @(negedge CLK);
        Reset = 1'b1;
        @(negedge CLK);
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || Product !== 16'h0000 ||
            ALUOp !== 2'b00 || ALUSrcA !== 8'h00 || ALUSrcB !== 8'h00) begin
            errors++;
            $display("FAIL mid reset: busy=%b done=%b product=%h op=%b a=%h b=%h want all 0",
                     Busy, Done, Product, ALUOp, ALUSrcA, ALUSrcB);
        end
        Reset = 1'b0;
        repeat (4) @(negedge CLK);
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || Product !== 16'h0000) begin
            errors++;
            $display("FAIL post reset idle: busy=%b done=%b product=%h want 0 0 0000", Busy, Done, Product);
        end
        run_mult(8'd6, 8'd7, 1'b0, 1'b0, "6x7");
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; MultA = 8'h00; MultB = 8'h00;
        test_reset();
        test_directed();
        test_operand_change();
        test_extra_start();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
